// File: rtl/adxl345_iic_master.sv
// adxl345_iic_master: I2C initiator for ADXL345-style register bursts
// (write burst, or read burst with repeated start) on an open-drain bus.
// Optional build macro IIC_CLOCK_STRETCH_EN: wait for SCL to read high
// after releasing it before moving past that quarter.
`timescale 1ns/1ps
module adxl345_iic_master #(
  parameter int QUARTER_DIV = 250,
  parameter int MAX_BURST   = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic                         cmd_rnw,
  input  logic [6:0]                   cmd_dev_addr,
  input  logic [7:0]                   cmd_reg_addr,
  input  logic [$clog2(MAX_BURST)-1:0] cmd_len,
  input  logic [7:0]                   wdata,
  input  logic                         wdata_valid,
  output logic                         wdata_ready,
  output logic [7:0]                   rdata,
  output logic                         rdata_valid,
  output logic                         done,
  output logic                         nack_err,
  output logic                         busy,
  input  logic                         IIC_SCL_I,
  input  logic                         IIC_SDA_I,
  output logic                         IIC_SCL_O,
  output logic                         IIC_SDA_O
);
  localparam int LW = $clog2(MAX_BURST);
  localparam int QW = (QUARTER_DIV > 1) ? $clog2(QUARTER_DIV) : 1;
  localparam logic [QW-1:0] QLAST = QW'(QUARTER_DIV - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDR_W, S_ACK1, S_REG, S_ACK2, S_WDATA, S_WACK,
    S_RESTART, S_ADDR_R, S_ACK3, S_RDATA, S_MACK, S_STOP
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    ph_q, ph_d;
  logic [QW-1:0] qcnt_q, qcnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic          ack_q, ack_d;
  logic          nack_q, nack_d;
  logic          scl_q, scl_d, sda_q, sda_d;
  logic [7:0]    tx_q, tx_d, rx_q, rx_d;
  logic [6:0]    dev_q;
  logic [7:0]    reg_q;
  logic [LW-1:0] len_q;
  logic          rnw_q;
  logic          load_cmd, hold, starve, tick, last_byte;

`ifndef IIC_CLOCK_STRETCH_EN
  logic unused_scl_i;
  assign unused_scl_i = IIC_SCL_I;
`endif

  assign cmd_ready = (state_q == S_IDLE) && !reset;
  assign busy      = (state_q != S_IDLE);
  assign rdata     = rx_q;
  assign IIC_SCL_O = scl_q;
  assign IIC_SDA_O = sda_q;

  // Next-state logic: ph_q names the action taken at the end of the current quarter
  always_comb begin
    state_d = state_q; ph_d = ph_q; qcnt_d = qcnt_q; bit_d = bit_q; cnt_d = cnt_q;
    ack_d = ack_q; nack_d = nack_q; scl_d = scl_q; sda_d = sda_q;
    tx_d = tx_q; rx_d = rx_q; load_cmd = 1'b0;
    wdata_ready = 1'b0; rdata_valid = 1'b0; done = 1'b0; nack_err = 1'b0;
    hold = 1'b0;
`ifdef IIC_CLOCK_STRETCH_EN
    hold = (state_q != S_IDLE) && (ph_q == 2'd2) && !IIC_SCL_I;
`endif
    starve    = (state_q == S_WDATA) && (ph_q == 2'd0) && (bit_q == 3'd0) && !wdata_valid;
    last_byte = (cnt_q == len_q);
    tick      = (state_q != S_IDLE) && (qcnt_q == QLAST) && !hold && !starve;

    if (state_q == S_IDLE)   qcnt_d = '0;
    else if (qcnt_q != QLAST) qcnt_d = qcnt_q + QW'(1);
    else if (tick)           qcnt_d = '0;

    if (state_q == S_IDLE) begin
      if (cmd_valid) begin
        load_cmd = 1'b1; state_d = S_START; ph_d = 2'd0; bit_d = 3'd0;
        cnt_d = '0; nack_d = 1'b0; tx_d = {cmd_dev_addr, 1'b0};
      end
    end else if (tick) begin
      ph_d = ph_q + 2'd1;
      case (ph_q)
        2'd0: begin // SCL low: place the next SDA value
          case (state_q)
            S_RESTART: sda_d = 1'b1;
            S_STOP:    sda_d = 1'b0;
            S_ACK1, S_ACK2, S_ACK3, S_WACK, S_RDATA: sda_d = 1'b1;
            S_MACK:    sda_d = last_byte;
            S_WDATA: begin
              if (bit_q == 3'd0) begin
                wdata_ready = 1'b1; tx_d = wdata; sda_d = wdata[7];
              end else begin
                sda_d = tx_q[7];
              end
            end
            S_ADDR_W, S_REG, S_ADDR_R: sda_d = tx_q[7];
            default: ;
          endcase
        end
        2'd1: begin // START pulls SDA under high SCL, everything else raises SCL
          if (state_q == S_START) sda_d = 1'b0;
          else                    scl_d = 1'b1;
        end
        2'd2: begin // SCL high: sample, or form Sr / STOP edges
          case (state_q)
            S_RESTART: sda_d = 1'b0;
            S_STOP:    sda_d = 1'b1;
            S_RDATA:   rx_d  = {rx_q[6:0], IIC_SDA_I};
            S_ACK1, S_ACK2, S_ACK3, S_WACK: ack_d = IIC_SDA_I;
            default: ;
          endcase
        end
        default: begin // SCL falls, advance bit / state
          if (state_q == S_STOP) begin
            done = 1'b1; nack_err = nack_q; state_d = S_IDLE;
          end else begin
            scl_d = 1'b0;
            case (state_q)
              S_START:   state_d = S_ADDR_W;
              S_RESTART: begin tx_d = {dev_q, 1'b1}; state_d = S_ADDR_R; end
              S_ADDR_W, S_REG, S_WDATA, S_ADDR_R: begin
                tx_d = {tx_q[6:0], 1'b0};
                bit_d = bit_q + 3'd1;
                if (bit_q == 3'd7) begin
                  case (state_q)
                    S_ADDR_W: state_d = S_ACK1;
                    S_REG:    state_d = S_ACK2;
                    S_WDATA:  state_d = S_WACK;
                    default:  state_d = S_ACK3;
                  endcase
                end
              end
              S_RDATA: begin
                bit_d = bit_q + 3'd1;
                if (bit_q == 3'd7) begin rdata_valid = 1'b1; state_d = S_MACK; end
              end
              S_ACK1, S_ACK2, S_ACK3, S_WACK: begin
                if (ack_q) begin
                  nack_d = 1'b1; state_d = S_STOP;
                end else begin
                  case (state_q)
                    S_ACK1:  begin tx_d = reg_q; state_d = S_REG; end
                    S_ACK2:  state_d = rnw_q ? S_RESTART : S_WDATA;
                    S_ACK3:  state_d = S_RDATA;
                    default: begin
                      if (last_byte) state_d = S_STOP;
                      else begin cnt_d = cnt_q + LW'(1); state_d = S_WDATA; end
                    end
                  endcase
                end
              end
              S_MACK: begin
                if (last_byte) state_d = S_STOP;
                else begin cnt_d = cnt_q + LW'(1); state_d = S_RDATA; end
              end
              default: ;
            endcase
          end
        end
      endcase
    end

    if (reset) begin
      wdata_ready = 1'b0; rdata_valid = 1'b0; done = 1'b0; nack_err = 1'b0;
    end
  end

  // Control and bus-line registers; reset aborts and releases both lines
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE; ph_q <= 2'd0; qcnt_q <= '0; bit_q <= 3'd0; cnt_q <= '0;
      ack_q <= 1'b0; nack_q <= 1'b0; scl_q <= 1'b1; sda_q <= 1'b1; rx_q <= 8'h00;
    end else begin
      state_q <= state_d; ph_q <= ph_d; qcnt_q <= qcnt_d; bit_q <= bit_d; cnt_q <= cnt_d;
      ack_q <= ack_d; nack_q <= nack_d; scl_q <= scl_d; sda_q <= sda_d; rx_q <= rx_d;
    end
  end

  // Command fields and transmit shifter
  always_ff @(posedge clk) begin
    tx_q <= tx_d;
    if (load_cmd) begin
      dev_q <= cmd_dev_addr; reg_q <= cmd_reg_addr; len_q <= cmd_len; rnw_q <= cmd_rnw;
    end
  end
endmodule

// File: tb/tb_adxl345_iic_master.sv
// Scoreboard bench for adxl345_iic_master with a behavioural ADXL345-like slave.
`timescale 1ns/1ps
module tb_adxl345_iic_master;
  localparam int QD = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1;
  logic cmd_valid = 1'b0, cmd_ready, cmd_rnw = 1'b0;
  logic [6:0] cmd_dev_addr = '0;
  logic [7:0] cmd_reg_addr = '0;
  logic [5:0] cmd_len = '0;
  logic [7:0] wdata = '0, rdata;
  logic wdata_valid = 1'b0, wdata_ready, rdata_valid, done, nack_err, busy;
  logic IIC_SCL_O, IIC_SDA_O;
  logic sl_scl = 1'b1, sl_sda = 1'b1;
  wire  scl_bus = IIC_SCL_O & sl_scl;
  wire  sda_bus = IIC_SDA_O & sl_sda;

  adxl345_iic_master #(.QUARTER_DIV(QD), .MAX_BURST(64)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_rnw(cmd_rnw), .cmd_dev_addr(cmd_dev_addr), .cmd_reg_addr(cmd_reg_addr),
    .cmd_len(cmd_len), .wdata(wdata), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
    .rdata(rdata), .rdata_valid(rdata_valid), .done(done), .nack_err(nack_err), .busy(busy),
    .IIC_SCL_I(scl_bus), .IIC_SDA_I(sda_bus), .IIC_SCL_O(IIC_SCL_O), .IIC_SDA_O(IIC_SDA_O)
  );

  int n_assert = 0, n_fail = 0;
  int cyc = 0, done_cnt = 0, wr_cnt = 0;
  logic [7:0] exp_rd[$], exp_bus[$], wq[$];
  logic       exp_done[$], exp_mack[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents read data or completion
  always @(negedge clk) begin
    if (rdata_valid) begin
      if (exp_rd.size() == 0) check("rdata_unexpected", rdata_valid, 1'b0);
      else check("rdata", rdata, exp_rd.pop_front());
    end
    if (done) begin
      done_cnt++;
      if (exp_done.size() == 0) check("done_unexpected", done, 1'b0);
      else check("nack_err", nack_err, exp_done.pop_front());
    end else if (nack_err) begin
      check("nack_without_done", nack_err, 1'b0);
    end
  end

  // Write-data source: presents queue head, counts bytes the DUT takes
  always begin
    logic [7:0] taken;
    @(negedge clk);
    wdata_valid = (wq.size() > 0);
    wdata       = (wq.size() > 0) ? wq[0] : 8'h00;
    #1;
    if (wdata_ready) begin
      taken = wq.pop_front();
      wr_cnt++;
    end
  end

  // Behavioural slave at address 0x53 with auto-incrementing register pointer
  logic [7:0] slave_mem [256];
  logic [7:0] ssh = '0, sptr = '0;
  int   sb = 0, sph = 0; // sph: 0 idle, 1 addr, 2 reg, 3 write, 4 read
  logic srd = 1'b0, smack = 1'b1, p_scl = 1'b1, p_sda = 1'b1;
  always @(scl_bus or sda_bus) begin
    if (scl_bus && p_scl && (sda_bus != p_sda)) begin
      if (!sda_bus) begin sph = 1; sb = -1; end else sph = 0;
      sl_sda = 1'b1;
    end else if (scl_bus && !p_scl) begin
      if (sph != 0 && sb >= 0) begin
        if (sb < 8) begin
          if (sph != 4) ssh = {ssh[6:0], sda_bus};
        end else if (sph == 4) begin
          smack = sda_bus;
          if (exp_mack.size() == 0) check("mack_unexpected", 1'b1, 1'b0);
          else check("master_ack", smack, exp_mack.pop_front());
        end
      end
    end else if (!scl_bus && p_scl && sph != 0) begin
      if (sb < 0) sb = 0;
      else if (sb < 7) begin
        sb++;
        if (sph == 4) sl_sda = ssh[3'(7 - sb)];
      end else if (sb == 7) begin
        sb = 8;
        if (sph == 4) sl_sda = 1'b1;
        else begin
          if (exp_bus.size() == 0) check("bus_byte_unexpected", ssh, 8'hXX);
          else check("bus_byte", ssh, exp_bus.pop_front());
          case (sph)
            1: if (ssh[7:1] == 7'h53) begin srd = ssh[0]; sl_sda = 1'b0; end else sph = 0;
            2: begin sptr = ssh; sl_sda = 1'b0; end
            default: begin slave_mem[sptr] = ssh; sptr++; sl_sda = 1'b0; end
          endcase
        end
      end else begin
        sl_sda = 1'b1; sb = 0;
        case (sph)
          1: if (srd) begin sph = 4; ssh = slave_mem[sptr]; sl_sda = ssh[7]; end else sph = 2;
          2: sph = 3;
          4: if (!smack) begin sptr++; ssh = slave_mem[sptr]; sl_sda = ssh[7]; end else sph = 0;
          default: ;
        endcase
      end
    end
    p_scl = scl_bus; p_sda = sda_bus;
  end

  task automatic send_cmd(input logic rnw, input logic [6:0] dev, input logic [7:0] ra,
                          input logic [5:0] len);
    int k = 0;
    @(negedge clk);
    cmd_rnw = rnw; cmd_dev_addr = dev; cmd_reg_addr = ra; cmd_len = len; cmd_valid = 1'b1;
    #1;
    while (!cmd_ready && k < 5000) begin @(negedge clk); #1; k++; end
    if (!cmd_ready) check("cmd_accept_timeout", cmd_ready, 1'b1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int start_cnt, input string nm);
    int k = 0;
    while (done_cnt == start_cnt && k < 20000) begin @(negedge clk); k++; end
    check(nm, done_cnt, start_cnt + 1);
  endtask

  task automatic wait_scl_rises(input int n, input string nm);
    int seen = 0, k = 0;
    logic p;
    p = IIC_SCL_O;
    while (seen < n && k < 10000) begin
      @(negedge clk);
      if (IIC_SCL_O && !p) seen++;
      p = IIC_SCL_O; k++;
    end
    check(nm, seen, n);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, w0, hi, k, t0, t1;
    logic p;
    for (int i = 0; i < 256; i++) slave_mem[i] = 8'h00;
    slave_mem[8'h00] = 8'hE5;
    for (int i = 0; i < 6; i++) slave_mem[8'h32 + i] = (i % 2 == 0) ? 8'hF0 : 8'hFF;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1'b0);
    check("rst_scl", IIC_SCL_O, 1'b1);
    check("rst_sda", IIC_SDA_O, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    reset = 1'b0;
    #1 check("ready_after_reset", cmd_ready, 1'b1);

    // Single write: 0x0F to reg 0x2E
    d0 = done_cnt; w0 = wr_cnt;
    wq.push_back(8'h0F);
    exp_bus.push_back(8'hA6); exp_bus.push_back(8'h2E); exp_bus.push_back(8'h0F);
    exp_done.push_back(1'b0);
    send_cmd(1'b0, 7'h53, 8'h2E, 6'd0);
    check("busy_after_accept", busy, 1'b1);
    check("ready_low_busy", cmd_ready, 1'b0);
    wait_done(d0, "write_done");
    check("write_wdata_ready_count", wr_cnt - w0, 1);
    check("slave_reg_2E", slave_mem[8'h2E], 8'h0F);

    // Single read of reg 0x00
    d0 = done_cnt;
    exp_bus.push_back(8'hA6); exp_bus.push_back(8'h00); exp_bus.push_back(8'hA7);
    exp_rd.push_back(8'hE5); exp_mack.push_back(1'b1); exp_done.push_back(1'b0);
    send_cmd(1'b1, 7'h53, 8'h00, 6'd0);
    wait_done(d0, "read1_done");

    // Burst read of six bytes from 0x32
    d0 = done_cnt;
    exp_bus.push_back(8'hA6); exp_bus.push_back(8'h32); exp_bus.push_back(8'hA7);
    for (int i = 0; i < 6; i++) begin
      exp_rd.push_back((i % 2 == 0) ? 8'hF0 : 8'hFF);
      exp_mack.push_back(i == 5);
    end
    exp_done.push_back(1'b0);
    send_cmd(1'b1, 7'h53, 8'h32, 6'd5);
    wait_done(d0, "burst_done");

    // Address NACK: no device at 0x1D
    d0 = done_cnt; w0 = wr_cnt;
    wq.push_back(8'h55);
    exp_bus.push_back(8'h3A); exp_done.push_back(1'b1);
    send_cmd(1'b0, 7'h1D, 8'h2D, 6'd0);
    wait_done(d0, "nack_done");
    check("nack_no_wdata_taken", wr_cnt - w0, 0);
    @(negedge clk); wq.delete();
    repeat (2) @(negedge clk);

    // Write underflow: second byte withheld for 1000 cycles
    d0 = done_cnt; w0 = wr_cnt;
    wq.push_back(8'hA1);
    exp_bus.push_back(8'hA6); exp_bus.push_back(8'h1E);
    exp_bus.push_back(8'hA1); exp_bus.push_back(8'hB2);
    exp_done.push_back(1'b0);
    send_cmd(1'b0, 7'h53, 8'h1E, 6'd1);
    k = 0;
    while (wr_cnt == w0 && k < 5000) begin @(negedge clk); k++; end
    check("underflow_first_taken", wr_cnt - w0, 1);
    wait_scl_rises(9, "underflow_first_byte_clocks");
    k = 0;
    while (IIC_SCL_O && k < 100) begin @(negedge clk); k++; end
    hi = 0;
    repeat (1000) begin @(negedge clk); if (IIC_SCL_O) hi++; end
    check("underflow_scl_held_low", hi, 0);
    check("underflow_no_extra_take", wr_cnt - w0, 1);
    wq.push_back(8'hB2);
    wait_done(d0, "underflow_done");
    check("underflow_reg_1E", slave_mem[8'h1E], 8'hA1);
    check("underflow_reg_1F", slave_mem[8'h1F], 8'hB2);

    // Reset during bit 3 of the register byte, then a normal read
    d0 = done_cnt;
    wq.push_back(8'h08);
    exp_bus.push_back(8'hA6);
    send_cmd(1'b0, 7'h53, 8'h2D, 6'd0);
    wait_scl_rises(13, "abort_reach_reg_bit3");
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_scl_released", IIC_SCL_O, 1'b1);
    check("abort_sda_released", IIC_SDA_O, 1'b1);
    check("abort_busy", busy, 1'b0);
    wq.delete();
    repeat (20) @(negedge clk);
    check("abort_no_done", done_cnt, d0);
    exp_bus.push_back(8'hA6); exp_bus.push_back(8'h2E); exp_bus.push_back(8'hA7);
    exp_rd.push_back(8'h0F); exp_mack.push_back(1'b1); exp_done.push_back(1'b0);
    send_cmd(1'b1, 7'h53, 8'h2E, 6'd0);
    wait_done(d0, "post_abort_done");

`ifdef IIC_CLOCK_STRETCH_EN
    // Slave holds SCL low for 500 cycles inside one bit
    d0 = done_cnt;
    exp_bus.push_back(8'hA6); exp_bus.push_back(8'h00); exp_bus.push_back(8'hA7);
    exp_rd.push_back(8'hE5); exp_mack.push_back(1'b1); exp_done.push_back(1'b0);
    send_cmd(1'b1, 7'h53, 8'h00, 6'd0);
    wait_scl_rises(3, "stretch_reach_bit");
    k = 0;
    while (IIC_SCL_O && k < 100) begin @(negedge clk); k++; end
    sl_scl = 1'b0; t0 = cyc;
    repeat (500) @(negedge clk);
    sl_scl = 1'b1;
    p = IIC_SCL_O; k = 0;
    while (!(p && !IIC_SCL_O) && k < 1000) begin p = IIC_SCL_O; @(negedge clk); k++; end
    t1 = cyc;
    check("stretch_bit_extended", (t1 - t0) >= 500, 1'b1);
    wait_done(d0, "stretch_done");
`endif

    repeat (10) @(negedge clk);
    check("queues_drained", exp_rd.size() + exp_bus.size() + exp_mack.size() + exp_done.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/adxl345_iic_master.md
Name: adxl345_iic_master

Overview:
I2C initiator that performs ADXL345-style register transactions on a two-wire open-drain bus.
- Accepts one command per handshake, either a burst write or a burst read with repeated start.
- Streams write data in and read data out.
- Sits between the sensor-control logic (config writes, interrupt-source and DATAX0..DATAZ1 reads) and the IIC pins or bus model.

Parameters:
- QUARTER_DIV, 250: clk cycles per SCL quarter period. Must be ≥ 2. SCL period = 4*QUARTER_DIV.
- MAX_BURST, 64: maximum bytes per command. cmd_len width is clog2(MAX_BURST).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  block idle and able to accept a command.
- cmd_rnw  in  1  1 = read, 0 = write.
- cmd_dev_addr  in  7  7-bit slave address.
- cmd_reg_addr  in  8  starting register pointer.
- cmd_len  in  6  byte count minus 1 (0 = 1 byte, 63 = 64 bytes).
- wdata  in  8  write byte.
- wdata_valid  in  1  write byte available.
- wdata_ready  out  1  write byte consumed this cycle.
- rdata  out  8  read byte.
- rdata_valid  out  1  1-cycle pulse per read byte. No backpressure.
- done  out  1  1-cycle pulse when STOP completes.
- nack_err  out  1  1-cycle pulse, coincident with done, if the slave NACKed.
- busy  out  1  high from command accept to done.
- IIC_SCL_I  in  1  sampled bus SCL.
- IIC_SDA_I  in  1  sampled bus SDA.
- IIC_SCL_O  out  1  1 = release, 0 = drive low.
- IIC_SDA_O  out  1  1 = release, 0 = drive low.

Behaviour:
Reset values:
- IIC_SCL_O=1, IIC_SDA_O=1, cmd_ready=0 during reset, 1 on the first cycle after reset.
- All other outputs 0. State = IDLE. Quarter counter = 0.
- Reset mid-transaction aborts immediately and releases both lines. No STOP is generated, and done is not pulsed.

Handshake:
- Command is accepted on cmd_valid & cmd_ready. All cmd_* fields are latched.
- cmd_ready drops on the next cycle and stays low until the cycle after done.

Bit timing:
- A tick fires every QUARTER_DIV clk cycles, phases q0..q3.
- SDA changes only at q0 (SCL low). SCL rises at q1, master samples SDA at q2, SCL falls at q3.
- START: SDA falls while SCL is high, then SCL falls.
- Repeated start (Sr): release SDA, raise SCL, then SDA falls.
- STOP: SDA low, SCL high, then SDA rises.
- Bits are sent MSB first.

State sequence:
- IDLE -> START -> ADDR_W (dev<<1|0) -> ACK1 -> REG -> ACK2.
- Write path: ACK2 -> WDATA -> WACK, repeated cmd_len+1 times -> STOP -> IDLE.
- Read path: ACK2 -> RESTART -> ADDR_R (dev<<1|1) -> ACK3 -> RDATA -> MACK, repeated cmd_len+1 times -> STOP -> IDLE.

Write data:
- wdata_ready pulses for 1 cycle at q0 of the first bit of each WDATA byte, only if wdata_valid is high.
- If wdata_valid is low at that point, SCL is held low and the phase counter frozen until valid rises.

Read data:
- Bits are shifted in at q2.
- rdata_valid pulses at the tick following the 8th q2, before MACK drives.
- MACK drives ACK (SDA=0) on all but the last byte, and NACK (SDA released) on the last byte.

NACK handling:
- Any slave ACK slot sampling SDA=1 goes straight to STOP. nack_err pulses with done.
- Remaining wdata is not consumed, and no further rdata is produced.

Other rules:
- busy = (state != IDLE).
- Commands presented while busy are not accepted (cmd_ready=0). The requester holds cmd_valid.
- cmd_len=0 transfers exactly 1 data byte. cmd_len=63 transfers 64.
- The register pointer is not incremented by the master. The slave auto-increments.

Optional Feature:
- Macro: IIC_CLOCK_STRETCH_EN.
- Defined: after releasing SCL at q1, the phase counter does not advance until IIC_SCL_I reads 1, so a slave holding SCL low stalls the transfer. This applies to every bit, ACK, Sr and STOP.
- Undefined: IIC_SCL_I is ignored and timing is purely counter-driven.

Test Plan:
1. Single read: read, dev 0x53, reg 0x00, len 0, slave model returns 0xE5 -> bus bytes 0xA6, 0x00, Sr, 0xA7. One rdata_valid with rdata=0xE5. Master NACKs it. done=1, nack_err=0.
2. Single write: write, dev 0x53, reg 0x2E, wdata 0x0F -> bus bytes 0xA6, 0x2E, 0x0F all ACKed, then STOP. Exactly 1 wdata_ready. Slave register 0x2E reads back 0x0F.
3. Burst read: reg 0x32, len 5 -> six rdata_valid pulses with slave bytes F0 FF F0 FF F0 FF. ACK on the first five, NACK on the sixth.
4. Address NACK: dev 0x1D with no responder -> STOP right after ACK1. done and nack_err pulse on the same cycle. No wdata_ready or rdata_valid.
5. Write underflow: wdata_valid held low 1000 cycles at the second byte -> SCL stays low, no bit lost. Transfer resumes when valid rises.
6. Reset at bit 3 of REG -> next cycle IIC_SCL_O=IIC_SDA_O=1, busy=0, no done. A following command completes normally. With IIC_CLOCK_STRETCH_EN, a slave holding SCL low 500 cycles extends that bit by ≥ 500 cycles.
